// File: rtl/arcade_input_pkg.sv
// Shared scancodes, control bit positions and joystick bit positions for the arcade input path.
// Scancodes carry a flag that makes the PS/2 extended bit a don't-care.
package arcade_input_pkg;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int FIRE  = 4;
    localparam int BOMB  = 5;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_BOMB   = 5;
    localparam int JOY_START1 = 6;
    localparam int JOY_START2 = 7;

    typedef struct packed {
        logic       ext_dc;
        logic [8:0] code;
    } scancode_t;

    localparam scancode_t SC_P1_UP    = '{1'b1, 9'h075};
    localparam scancode_t SC_P1_DOWN  = '{1'b1, 9'h072};
    localparam scancode_t SC_P1_LEFT  = '{1'b1, 9'h06B};
    localparam scancode_t SC_P1_RIGHT = '{1'b1, 9'h074};
    localparam scancode_t SC_P1_FIRE  = '{1'b0, 9'h029};
    localparam scancode_t SC_P1_BOMB  = '{1'b1, 9'h014};
    localparam scancode_t SC_P2_UP    = '{1'b0, 9'h02D};
    localparam scancode_t SC_P2_DOWN  = '{1'b0, 9'h02B};
    localparam scancode_t SC_P2_LEFT  = '{1'b0, 9'h023};
    localparam scancode_t SC_P2_RIGHT = '{1'b0, 9'h034};
    localparam scancode_t SC_P2_FIRE  = '{1'b0, 9'h01C};
    localparam scancode_t SC_P2_BOMB  = '{1'b0, 9'h01B};
    localparam scancode_t SC_START1A  = '{1'b0, 9'h005};
    localparam scancode_t SC_START1B  = '{1'b0, 9'h016};
    localparam scancode_t SC_START2A  = '{1'b0, 9'h006};
    localparam scancode_t SC_START2B  = '{1'b0, 9'h01E};
    localparam scancode_t SC_COIN1    = '{1'b0, 9'h02E};
    localparam scancode_t SC_COIN2    = '{1'b0, 9'h036};

    // Key register slots; each player's six slots follow the UP..BOMB order.
    localparam int KEY_P1_BASE = 0;
    localparam int KEY_P2_BASE = 6;
    localparam int KEY_START1A = 12;
    localparam int KEY_START1B = 13;
    localparam int KEY_START2A = 14;
    localparam int KEY_START2B = 15;
    localparam int KEY_COIN1   = 16;
    localparam int KEY_COIN2   = 17;
    localparam int KEY_COUNT   = 18;

    localparam scancode_t KEY_TABLE [KEY_COUNT] = '{
        SC_P1_UP, SC_P1_DOWN, SC_P1_LEFT, SC_P1_RIGHT, SC_P1_FIRE, SC_P1_BOMB,
        SC_P2_UP, SC_P2_DOWN, SC_P2_LEFT, SC_P2_RIGHT, SC_P2_FIRE, SC_P2_BOMB,
        SC_START1A, SC_START1B, SC_START2A, SC_START2B, SC_COIN1, SC_COIN2
    };

    function automatic logic key_match(input logic [8:0] code, input scancode_t sc);
        return (code[7:0] == sc.code[7:0]) && (sc.ext_dc || (code[8] == sc.code[8]));
    endfunction

    // Horizontal orientation: up<-left, down<-right, left<-down, right<-up.
    function automatic logic [5:0] orient(input logic [5:0] c, input logic rot);
        logic [5:0] r;
        r = c;
        if (rot) begin
            r[UP]    = c[LEFT];
            r[DOWN]  = c[RIGHT];
            r[LEFT]  = c[DOWN];
            r[RIGHT] = c[UP];
        end
        return r;
    endfunction

endpackage

// File: rtl/coin_pulse_stretcher.sv
// Turns a rising edge of req into a pulse exactly COIN_CYCLES clocks wide.
// Edges seen while a pulse is running are dropped, not queued.
module coin_pulse_stretcher #(
    parameter int COIN_CYCLES = 1800000,
    parameter int CW          = 21
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    output logic pulse
);

    logic          req_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= 1'b0;
            cnt   <= '0;
        end else begin
            req_q <= req;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            else if (req && !req_q)
                cnt <= CW'(COIN_CYCLES);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/arcade_key_mapper.sv
// PS/2 key events and MiSTer joystick words to registered two-player arcade controls,
// with horizontal-orientation remap and a fixed-width coin pulse.
module arcade_key_mapper
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES = 1800000,
    parameter int CW          = 21
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic [5:0]  p1_ctrl,
    output logic [5:0]  p2_ctrl,
    output logic        start1,
    output logic        start2,
    output logic        coin
);

    logic                 tog_q;
    logic [KEY_COUNT-1:0] key_q;
    logic                 key_event;

    assign key_event = ps2_key[10] ^ tog_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q <= 1'b0;
            key_q <= '0;
        end else begin
            tog_q <= ps2_key[10];
            for (int i = 0; i < KEY_COUNT; i++) begin
                if (key_event && key_match(ps2_key[8:0], KEY_TABLE[i]))
                    key_q[i] <= ps2_key[9];
            end
        end
    end

    logic [15:0] joy;
    logic [5:0]  joy_ctrl;
    logic [5:0]  p1_raw;
    logic [5:0]  p2_raw;
    logic        start1_raw;
    logic        start2_raw;
    logic        coin_req;
    logic        unused_joy;

    assign joy        = joystick_0 | joystick_1;
    assign unused_joy = ^joy[15:8];

    always_comb begin
        joy_ctrl        = '0;
        joy_ctrl[UP]    = joy[JOY_UP];
        joy_ctrl[DOWN]  = joy[JOY_DOWN];
        joy_ctrl[LEFT]  = joy[JOY_LEFT];
        joy_ctrl[RIGHT] = joy[JOY_RIGHT];
        joy_ctrl[FIRE]  = joy[JOY_FIRE];
        joy_ctrl[BOMB]  = joy[JOY_BOMB];
    end

    assign p1_raw     = key_q[KEY_P1_BASE +: 6] | joy_ctrl;
    assign p2_raw     = key_q[KEY_P2_BASE +: 6] | joy_ctrl;
    assign start1_raw = key_q[KEY_START1A] | key_q[KEY_START1B] | joy[JOY_START1];
    assign start2_raw = key_q[KEY_START2A] | key_q[KEY_START2B] | joy[JOY_START2];
    assign coin_req   = key_q[KEY_COIN1] | key_q[KEY_COIN2] | start1_raw | start2_raw;

    // Rotation is applied on the output side only, so held keys survive a rotate change.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
            start1  <= 1'b0;
            start2  <= 1'b0;
        end else begin
            p1_ctrl <= orient(p1_raw, rotate);
            p2_ctrl <= orient(p2_raw, rotate);
            start1  <= start1_raw;
            start2  <= start2_raw;
        end
    end

    coin_pulse_stretcher #(
        .COIN_CYCLES (COIN_CYCLES),
        .CW          (CW)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req     (coin_req),
        .pulse   (coin)
    );

endmodule

// File: tb/tb_arcade_key_mapper.sv
// Bench for arcade_key_mapper: table-driven key/joystick vectors through a scoreboard queue,
// plus hand sequences for coin width, start retrigger and asynchronous reset.
module tb_arcade_key_mapper;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic [5:0]  p1_ctrl;
    logic [5:0]  p2_ctrl;
    logic        start1;
    logic        start2;
    logic        coin;

    arcade_key_mapper #(.COIN_CYCLES(8), .CW(4)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate     (rotate),
        .p1_ctrl    (p1_ctrl),
        .p2_ctrl    (p2_ctrl),
        .start1     (start1),
        .start2     (start2),
        .coin       (coin)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        ev;
        logic        pressed;
        logic [8:0]  code;
        logic [15:0] j0;
        logic [15:0] j1;
        logic        rot;
        logic [5:0]  p1;
        logic [5:0]  p2;
        logic        s1;
        logic        s2;
    } vec_t;

    typedef struct {
        int         due;
        int         idx;
        logic [13:0] outs;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic tog = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic ev, input logic pr, input logic [8:0] code,
                                input logic [15:0] j0, input logic [15:0] j1, input logic rot,
                                input logic [5:0] p1, input logic [5:0] p2,
                                input logic s1, input logic s2);
        vec_t v;
        v.ev = ev; v.pressed = pr; v.code = code; v.j0 = j0; v.j1 = j1; v.rot = rot;
        v.p1 = p1; v.p2 = p2; v.s1 = s1; v.s2 = s2;
        return v;
    endfunction

    // Scoreboard consumer: compares the head entry when its due edge arrives.
    always begin
        @(posedge clk_sys);
        cyc = cyc + 1;
        #2;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk($sformatf("vec%0d", mon_e.idx), {18'd0, p1_ctrl, p2_ctrl, start1, start2},
                {18'd0, mon_e.outs});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pr, input logic [8:0] code);
        tog = ~tog;
        ps2_key = {tog, pr, code};
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        if (v.ev) tog = ~tog;
        ps2_key    = {tog, v.pressed, v.code};
        joystick_0 = v.j0;
        joystick_1 = v.j1;
        rotate     = v.rot;
        e.due  = cyc + 2;
        e.idx  = idx;
        e.outs = {v.p1, v.p2, v.s1, v.s2};
        sb.push_back(e);
        tick(3);
    endtask

    task automatic watch_coin(input int n, output int highs, output int first);
        highs = 0;
        first = -1;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            if (coin) begin
                highs++;
                if (first < 0) first = k;
            end
        end
    endtask

    int highs;
    int first;

    initial begin
        reset_n    = 1'b0;
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        rotate     = 1'b0;

        //     ev pr code     j0       j1       rot p1         p2         s1 s2
        vecs.push_back(mk(1, 1, 9'h175, 16'h0, 16'h0, 0, 6'b000001, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h175, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h075, 16'h0, 16'h0, 0, 6'b000001, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h075, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h129, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h029, 16'h0, 16'h0, 0, 6'b010000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h029, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h06B, 16'h0, 16'h0, 0, 6'b000100, 6'b000000, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0, 16'h0, 1, 6'b000001, 6'b000000, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0, 16'h0, 0, 6'b000100, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h16B, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h023, 16'h0, 16'h0, 1, 6'b000000, 6'b000001, 0, 0));
        vecs.push_back(mk(1, 1, 9'h074, 16'h0, 16'h0, 1, 6'b000010, 6'b000001, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0, 16'h0, 0, 6'b001000, 6'b000100, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0001, 16'h0, 0, 6'b001000, 6'b001100, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0, 16'h0030, 0, 6'b111000, 6'b110100, 0, 0));
        vecs.push_back(mk(1, 0, 9'h074, 16'h0, 16'h0, 0, 6'b000000, 6'b000100, 0, 0));
        vecs.push_back(mk(1, 0, 9'h023, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h02D, 16'h0, 16'h0, 0, 6'b000000, 6'b000001, 0, 0));
        vecs.push_back(mk(1, 0, 9'h02D, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h016, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 1, 0));
        vecs.push_back(mk(1, 0, 9'h016, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h01E, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 1));
        vecs.push_back(mk(1, 0, 9'h01E, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0080, 16'h0, 0, 6'b000000, 6'b000000, 0, 1));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h114, 16'h0, 16'h0, 0, 6'b100000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h014, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(1, 1, 9'h01B, 16'h0, 16'h0, 0, 6'b000000, 6'b100000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h01B, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0008, 16'h0, 1, 6'b001000, 6'b001000, 0, 0));
        vecs.push_back(mk(0, 0, 9'h000, 16'h0, 16'h0, 0, 6'b000000, 6'b000000, 0, 0));

        #1;
        chk("reset_outs_t1", {p1_ctrl, p2_ctrl, start1, start2, coin}, 15'd0);
        #21;
        chk("reset_outs_held", {p1_ctrl, p2_ctrl, start1, start2, coin}, 15'd0);
        reset_n = 1'b1;
        tick(1);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
        tick(12);
        chk("sb_drained", sb.size(), 0);
        chk("coin_idle", coin, 1'b0);

        // Coin key: 8-cycle pulse starting two edges after the event.
        send_key(1'b1, 9'h02E);
        watch_coin(6, highs, first);
        send_key(1'b0, 9'h02E);
        begin
            int h2, f2;
            watch_coin(10, h2, f2);
            chk("coin_width", highs + h2, 8);
        end
        chk("coin_first_edge", first, 2);

        // Coin key held 20+ cycles still yields one pulse.
        send_key(1'b1, 9'h02E);
        watch_coin(25, highs, first);
        chk("coin_held_width", highs, 8);
        chk("coin_held_first", first, 2);
        send_key(1'b0, 9'h02E);
        tick(12);

        // Start pressed twice 3 cycles apart: start follows, only one pulse.
        highs = 0;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            joystick_0 = (k == 1 || k == 4) ? 16'h0040 : 16'h0000;
            tick(1);
            if (k <= 6) chk($sformatf("start1_k%0d", k), start1, (k == 1 || k == 4));
            if (coin) begin
                highs++;
                if (first < 0) first = k;
            end
        end
        chk("start_coin_width", highs, 8);
        chk("start_coin_first", first, 1);
        joystick_0 = '0;
        tick(4);

        // Async reset mid-pulse, then a pending toggle decoded once.
        send_key(1'b1, 9'h075);
        tick(2);
        send_key(1'b1, 9'h036);
        tick(4);
        chk("pre_reset_coin", coin, 1'b1);
        chk("pre_reset_p1", p1_ctrl, 6'b000001);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {p1_ctrl, p2_ctrl, start1, start2, coin}, 15'd0);
        tog = 1'b1;
        ps2_key = {1'b1, 1'b1, 9'h075};
        tick(2);
        #3;
        reset_n = 1'b1;
        tick(1);
        chk("post_reset_edge1", p1_ctrl, 6'b000000);
        tick(1);
        chk("post_reset_edge2", p1_ctrl, 6'b000001);
        watch_coin(12, highs, first);
        chk("post_reset_no_coin", highs, 0);
        chk("post_reset_p1_hold", p1_ctrl, 6'b000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
